// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver driven by a 16x oversampling clock enable.
// Presents each good byte through a valid/acknowledge handshake, with overrun and framing-error flags.
module uart_rx_16x #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       UART_RX,
    input  logic       RX_ACK,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_OVR,
    output logic       RX_FERR,
    output logic       RX_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;

    state_t     state_r, state_s;
    logic [3:0] tick_cnt_r, tick_cnt_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic       good_s;
    logic       ferr_s;

    logic [7:0] data_r;
    logic       valid_r;
    logic       ovr_r;
    logic       ferr_r;
    logic       busy_r;

    // Metastability synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], UART_RX};
        end
    end

    assign rx_s = sync_r[SYNC_STAGES-1];

    // Frame FSM, bit-timing counters and shift register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            busy_r     <= (state_s != IDLE);
        end
    end

    // Next-state logic; everything advances only on baud ticks.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        good_s     = 1'b0;
        ferr_s     = 1'b0;
        if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_s    = START;
                        tick_cnt_s = 4'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (tick_cnt_r != 4'd7) begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end else if (!rx_s) begin
                        state_s    = DATA;
                        tick_cnt_s = 4'd0;
                        bit_cnt_s  = 3'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == 4'd15) begin
                        shift_s   = {rx_s, shift_r[7:1]};
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_s = STOP;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        state_s = DATA;
                    end
                end
                STOP: begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                    // Leave at mid stop bit so a following start edge is never missed.
                    if (tick_cnt_r == 4'd15) begin
                        state_s = IDLE;
                        if (rx_s) begin
                            good_s = 1'b1;
                        end else begin
                            ferr_s = 1'b1;
                        end
                    end else begin
                        state_s = STOP;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // CPU-side holding register, handshake and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            ferr_r <= ferr_s;
            if (good_s) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
                // Overrun only when the previous byte is still unconsumed this cycle.
                ovr_r   <= valid_r & ~RX_ACK;
            end else if (RX_ACK) begin
                valid_r <= 1'b0;
                ovr_r   <= 1'b0;
            end
        end
    end

    assign RX_DATA  = data_r;
    assign RX_VALID = valid_r;
    assign RX_OVR   = ovr_r;
    assign RX_FERR  = ferr_r;
    assign RX_BUSY  = busy_r;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed self-checking bench for uart_rx_16x: one task per scenario, baud tick every 4 clk.
module tb_uart_rx_16x;

    logic       clk;
    logic       reset;
    logic       baud_tick;
    logic       uart_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ovr;
    logic       rx_ferr;
    logic       rx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int tick_no = 0;

    uart_rx_16x #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_tick(baud_tick),
        .UART_RX  (uart_rx),
        .RX_ACK   (rx_ack),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_OVR   (rx_ovr),
        .RX_FERR  (rx_ferr),
        .RX_BUSY  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x baud enable: one clk high out of every four.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Tick edge counter used to place expectations relative to the start edge.
    always @(posedge clk) begin
        if (baud_tick) tick_no <= tick_no + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_tick();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (baud_tick !== 1'b1 && g < 16);
        #1;
    endtask

    task automatic wait_until(input int n);
        int g;
        g = 0;
        while (tick_no < n && g < 4000) begin
            wait_tick();
            g++;
        end
        n_cmp++;
        if (tick_no !== n) begin n_err++; $display("FAIL tick_wait: got %0d want %0d", tick_no, n); end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; 16 ticks each, no trailing idle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (16) wait_tick();
        end
        uart_rx = stop_bit;
        repeat (16) wait_tick();
        uart_rx = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", rx_ovr); end
        n_cmp++; if (rx_ferr !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", rx_ferr); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        reset = 1'b0;
        repeat (4) wait_tick();
    endtask

    task automatic test_single_byte();
        int a;
        wait_tick();
        a = tick_no;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_until(a + 152);
                n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", rx_valid); end
                n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", rx_busy); end
                wait_until(a + 153);
                n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rx_valid); end
                n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", rx_data); end
                n_cmp++; if (rx_ferr !== 1'b0) begin n_err++; $display("FAIL single_ferr: got %b want 0", rx_ferr); end
                n_cmp++; if (rx_ovr !== 1'b0) begin n_err++; $display("FAIL single_ovr: got %b want 0", rx_ovr); end
                n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", rx_busy); end
                ack_pulse();
                n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_ack: got %b want 0", rx_valid); end
            end
        join
    endtask

    task automatic test_back_to_back();
        int a;
        logic [7:0] exp_b [3];
        exp_b = '{8'h00, 8'hFF, 8'h55};
        wait_tick();
        a = tick_no;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h55, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_until(a + 160 * k + 153);
                    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, rx_valid); end
                    n_cmp++; if (rx_data !== exp_b[k]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rx_data, exp_b[k]); end
                    n_cmp++; if ({rx_ovr, rx_ferr} !== 2'b00) begin n_err++; $display("FAIL b2b_flags[%0d]: got %b want 00", k, {rx_ovr, rx_ferr}); end
                    ack_pulse();
                    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ack[%0d]: got %b want 0", k, rx_valid); end
                end
            end
        join
    endtask

    task automatic test_overrun();
        int a;
        wait_tick();
        a = tick_no;
        fork
            begin
                send_frame(8'h12, 1'b1);
                send_frame(8'h34, 1'b1);
            end
            begin
                wait_until(a + 153);
                n_cmp++; if ({rx_valid, rx_ovr, rx_data} !== {1'b1, 1'b0, 8'h12}) begin n_err++; $display("FAIL ovr_first: got v=%b o=%b d=%h want v=1 o=0 d=12", rx_valid, rx_ovr, rx_data); end
                wait_until(a + 313);
                n_cmp++; if (rx_data !== 8'h34) begin n_err++; $display("FAIL ovr_data: got %h want 34", rx_data); end
                n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
                n_cmp++; if (rx_ovr !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", rx_ovr); end
            end
        join
        ack_pulse();
        n_cmp++; if ({rx_valid, rx_ovr} !== 2'b00) begin n_err++; $display("FAIL ovr_ack: got %b want 00", {rx_valid, rx_ovr}); end

        wait_tick();
        a = tick_no;
        fork
            begin
                send_frame(8'h12, 1'b1);
                send_frame(8'h34, 1'b1);
            end
            begin
                wait_until(a + 153);
                n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr2_first: got %b want 1", rx_valid); end
                wait_until(a + 312);
                repeat (3) @(posedge clk);
                #1;
                rx_ack = 1'b1;
                @(posedge clk);
                #1;
                rx_ack = 1'b0;
                n_cmp++; if ({rx_valid, rx_ovr, rx_data} !== {1'b1, 1'b0, 8'h34}) begin n_err++; $display("FAIL ovr2_ack_edge: got v=%b o=%b d=%h want v=1 o=0 d=34", rx_valid, rx_ovr, rx_data); end
            end
        join
    endtask

    task automatic test_framing_error();
        int a;
        wait_tick();
        a = tick_no;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                wait_until(a + 153);
                n_cmp++; if (rx_ferr !== 1'b1) begin n_err++; $display("FAIL ferr_pulse: got %b want 1", rx_ferr); end
                n_cmp++; if ({rx_valid, rx_ovr, rx_data} !== {1'b1, 1'b0, 8'h34}) begin n_err++; $display("FAIL ferr_hold: got v=%b o=%b d=%h want v=1 o=0 d=34", rx_valid, rx_ovr, rx_data); end
                @(posedge clk);
                #1;
                n_cmp++; if (rx_ferr !== 1'b0) begin n_err++; $display("FAIL ferr_width: got %b want 0", rx_ferr); end
            end
        join
        ack_pulse();
        repeat (20) wait_tick();
        a = tick_no;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                wait_until(a + 153);
                n_cmp++; if ({rx_valid, rx_ferr, rx_ovr, rx_data} !== {1'b1, 1'b0, 1'b0, 8'h7E}) begin n_err++; $display("FAIL ferr_recover: got v=%b f=%b o=%b d=%h want v=1 f=0 o=0 d=7e", rx_valid, rx_ferr, rx_ovr, rx_data); end
            end
        join
    endtask

    task automatic test_glitch();
        int a;
        wait_tick();
        a = tick_no;
        uart_rx = 1'b0;
        wait_until(a + 5);
        uart_rx = 1'b1;
        wait_until(a + 8);
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy: got %b want 1", rx_busy); end
        wait_until(a + 9);
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b want 0", rx_busy); end
        n_cmp++; if ({rx_valid, rx_ovr, rx_ferr, rx_data} !== {1'b1, 1'b0, 1'b0, 8'h7E}) begin n_err++; $display("FAIL glitch_outputs: got v=%b o=%b f=%b d=%h want v=1 o=0 f=0 d=7e", rx_valid, rx_ovr, rx_ferr, rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int a;
        wait_tick();
        a = tick_no;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_until(a + 85);
                reset = 1'b1;
                #1;
                n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
                n_cmp++; if ({rx_valid, rx_ovr, rx_ferr, rx_busy} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags: got %b want 0000", {rx_valid, rx_ovr, rx_ferr, rx_busy}); end
            end
        join
        reset = 1'b0;
        repeat (4) wait_tick();
        a = tick_no;
        fork
            send_frame(8'h81, 1'b1);
            begin
                wait_until(a + 153);
                n_cmp++; if ({rx_valid, rx_ovr, rx_ferr, rx_data} !== {1'b1, 1'b0, 1'b0, 8'h81}) begin n_err++; $display("FAIL rstmid_next: got v=%b o=%b f=%b d=%h want v=1 o=0 f=0 d=81", rx_valid, rx_ovr, rx_ferr, rx_data); end
            end
        join
    endtask

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
